// File: rtl/stream_tools_pkg.sv
// rtl/stream_tools_pkg.sv - shared stream width and arbiter state encoding
package stream_tools_pkg;

  localparam int STREAM_W = 256;

  typedef enum logic {
    ARB_IDLE,
    ARB_XFER
  } arb_state_t;

endpackage

// File: rtl/stream_narrow_arbiter_if.sv
// rtl/stream_narrow_arbiter_if.sv - requester and narrower-side stream bundle for the arbiter
interface stream_narrow_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  import stream_tools_pkg::*;

  // Requester side: one lane of STREAM_W bits per requester
  logic [N_REQ-1:0]          req_mask;
  logic [N_REQ*STREAM_W-1:0] req_data;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_last;
  logic [N_REQ-1:0]          req_ready;

  // Narrower side: single granted stream tagged with source and last
  logic [STREAM_W-1:0]       nar_data;
  logic                      nar_valid;
  logic                      nar_ready;
  logic [ID_W-1:0]           nar_src;
  logic                      nar_last;

  // Environment view: drives requesters and narrower backpressure
  modport master (
    output req_mask, req_data, req_valid, req_last, nar_ready,
    input  req_ready, nar_data, nar_valid, nar_src, nar_last
  );

  // Arbiter view
  modport slave (
    input  req_mask, req_data, req_valid, req_last, nar_ready,
    output req_ready, nar_data, nar_valid, nar_src, nar_last
  );

endinterface

// File: rtl/stream_narrow_arbiter_rr_pick.sv
// rtl/stream_narrow_arbiter_rr_pick.sv - rotating priority encoder, first set bit at or after ptr
module stream_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] gnt_idx_o,
  output logic            any_o
);

  assign any_o = |req_i;

  // Scan N positions starting at ptr, wrapping, and keep the first requester found
  always_comb begin : pick_scan
    int              idx;
    logic [ID_W-1:0] idx_v;
    logic            found;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      idx_v = ID_W'(idx);
      if (!found && req_i[idx_v]) begin
        found     = 1'b1;
        gnt_idx_o = idx_v;
      end
    end
  end

endmodule

// File: rtl/stream_narrow_arbiter.sv
// rtl/stream_narrow_arbiter.sv - round-robin burst arbiter feeding a shared 256-bit narrower
module stream_narrow_arbiter
  import stream_tools_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BEATS = 8,
  parameter int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  stream_narrow_arbiter_if.slave  bus,
  output logic                    busy_o
);

  // One extra bit so MAX_BEATS-1 is always representable, including MAX_BEATS=1
  localparam int             CNT_W    = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] elig;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;

  // Pointer for the next arbitration: one past the requester just served
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
    if (int'(idx) + 1 >= N_REQ) begin
      return '0;
    end
    return ID_W'(int'(idx) + 1);
  endfunction

  // Masked-out requesters never enter arbitration even when valid
  assign elig = bus.req_valid & bus.req_mask;

  stream_rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_i     (elig),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Arbitration FSM next-state and combinational pass-through of the granted lane
  always_comb begin
    logic beat_acc;
    logic beat_last;
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    bus.req_ready = '0;
    bus.nar_data  = '0;
    bus.nar_valid = 1'b0;
    bus.nar_last  = 1'b0;
    bus.nar_src   = '0;
    busy_o        = 1'b0;
    beat_acc      = 1'b0;
    beat_last     = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_XFER;
        end
      end

      ARB_XFER: begin
        busy_o                 = 1'b1;
        bus.nar_src            = grant_q;
        bus.nar_data           = bus.req_data[int'(grant_q)*STREAM_W +: STREAM_W];
        bus.nar_valid          = bus.req_valid[grant_q];
        bus.req_ready[grant_q] = bus.nar_ready;
        // The beat cap closes the grant even if the requester's burst continues
        beat_last              = bus.req_last[grant_q] | (cnt_q == CNT_LAST);
        bus.nar_last           = beat_last;
        beat_acc               = bus.req_valid[grant_q] & bus.nar_ready;

        if (beat_acc) begin
          if (beat_last) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = wrap_inc(grant_q);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, grant, pointer and beat counter registers; reset abandons any burst
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // A grant index beyond the requester count would select a nonexistent lane
  assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ARB_XFER) |-> (int'(grant_q) < N_REQ));

endmodule

// File: tb/tb_stream_narrow_arbiter.sv
// tb/tb_stream_narrow_arbiter.sv - directed self-checking bench for stream_narrow_arbiter
module tb_stream_narrow_arbiter;
  import stream_tools_pkg::*;

  localparam int N_REQ     = 4;
  localparam int MAX_BEATS = 8;
  localparam int ID_W      = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  stream_narrow_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  stream_narrow_arbiter #(
    .N_REQ     (N_REQ),
    .MAX_BEATS (MAX_BEATS),
    .ID_W      (ID_W)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  int checks = 0;
  int errors = 0;

  int beats_left [N_REQ];
  int seq        [N_REQ];
  int reload     [N_REQ];
  int cyc;

  int                  log_src  [$];
  int                  log_last [$];
  int                  log_cyc  [$];
  logic [STREAM_W-1:0] log_data [$];
  int                  busy_hist[$];
  int                  g_src    [$];
  int                  g_len    [$];

  logic chk_rr    = 1'b0;
  logic chk_stall = 1'b0;
  logic watch2    = 1'b0;
  logic saw2      = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [STREAM_W-1:0] data_of(input int i, input int s);
    logic [31:0] w;
    w = {8'(i), 24'(s)};
    return {8{w}};
  endfunction

  function automatic int qget(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  function automatic logic [STREAM_W-1:0] dget(input int k);
    if (k < log_data.size()) return log_data[k];
    return '1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_valid[i] = (beats_left[i] > 0);
      bus.req_last[i]  = (beats_left[i] == 1);
      bus.req_data[i*STREAM_W +: STREAM_W] = data_of(i, seq[i]);
    end
  endtask

  task automatic clear_logs();
    log_src.delete();
    log_last.delete();
    log_cyc.delete();
    log_data.delete();
    busy_hist.delete();
    cyc = 0;
  endtask

  // sample at negedge, then advance requester models after the edge
  task automatic cycle(input logic rdy);
    logic [N_REQ-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    busy_hist.push_back(int'(busy));
    if (watch2 && bus.req_ready[2]) saw2 = 1'b1;
    if (chk_rr && busy) check("rr_tracks", bus.req_ready[0], bus.nar_ready);
    if (chk_stall && bus.nar_valid && !bus.nar_ready) begin
      check("stall_data", bus.nar_data, data_of(0, seq[0]));
      check("stall_src", bus.nar_src, 0);
    end
    if (bus.nar_valid && bus.nar_ready) begin
      log_src.push_back(int'(bus.nar_src));
      log_last.push_back(int'(bus.nar_last));
      log_cyc.push_back(cyc);
      log_data.push_back(bus.nar_data);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[i]) begin
        beats_left[i]--;
        seq[i]++;
        if (beats_left[i] == 0) beats_left[i] = reload[i];
      end
    end
    bus.nar_ready = rdy;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      beats_left[i] = 0;
      seq[i]        = 0;
      reload[i]     = 0;
    end
    bus.req_mask  = '1;
    bus.nar_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic build_grants();
    int n;
    n = 0;
    g_src.delete();
    g_len.delete();
    foreach (log_src[k]) begin
      n++;
      if (log_last[k] != 0) begin
        g_src.push_back(log_src[k]);
        g_len.push_back(n);
        n = 0;
      end
    end
  endtask

  initial begin
    int exp_src2 [6];
    int exp_src3 [5];
    int exp_len3 [5];
    int exp_src5 [5];
    exp_src2 = '{0, 1, 2, 3, 0, 1};
    exp_src3 = '{1, 3, 1, 3, 1};
    exp_len3 = '{8, 1, 8, 1, 4};
    exp_src5 = '{0, 1, 3, 1, 3};

    // reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_valid", bus.nar_valid, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_src", bus.nar_src, 0);
    check("rst_last", bus.nar_last, 0);

    // 1: single requester, 3-beat burst
    beats_left[2] = 3;
    drive();
    repeat (6) cycle(1'b1);
    check("t1_nbeats", log_src.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check("t1_src", qget(log_src, k), 2);
      check("t1_last", qget(log_last, k), (k == 2) ? 1 : 0);
      check("t1_cyc", qget(log_cyc, k), k + 1);
      check("t1_data", dget(k), data_of(2, k));
    end
    check("t1_busy_c0", qget(busy_hist, 0), 0);
    check("t1_busy_c3", qget(busy_hist, 3), 1);
    check("t1_busy_c4", qget(busy_hist, 4), 0);

    // 2: round robin, all continuously valid with 1-beat bursts
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      beats_left[i] = 1;
      reload[i]     = 1;
    end
    drive();
    repeat (13) cycle(1'b1);
    for (int k = 0; k < 6; k++) begin
      check("t2_src", qget(log_src, k), exp_src2[k]);
      check("t2_cyc", qget(log_cyc, k), 2*k + 1);
      check("t2_last", qget(log_last, k), 1);
    end

    // 3: beat cap splits a 20-beat burst
    do_reset();
    beats_left[1] = 20;
    beats_left[3] = 1;
    reload[3]     = 1;
    drive();
    repeat (30) cycle(1'b1);
    build_grants();
    for (int k = 0; k < 5; k++) begin
      check("t3_gsrc", qget(g_src, k), exp_src3[k]);
      check("t3_glen", qget(g_len, k), exp_len3[k]);
    end
    check("t3_split_data", dget(9), data_of(1, 8));
    check("t3_end_data", dget(21), data_of(1, 19));

    // 4: backpressure 1,0,0,1 during a 4-beat burst
    do_reset();
    beats_left[0] = 4;
    drive();
    chk_rr    = 1'b1;
    chk_stall = 1'b1;
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    repeat (4) cycle(1'b1);
    chk_rr    = 1'b0;
    chk_stall = 1'b0;
    check("t4_nbeats", log_src.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("t4_data", dget(k), data_of(0, k));
      check("t4_last", qget(log_last, k), (k == 3) ? 1 : 0);
    end
    check("t4_cyc1", qget(log_cyc, 1), 4);

    // 5: masking, bit 0 cleared mid-grant
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      beats_left[i] = 2;
      reload[i]     = 2;
    end
    bus.req_mask = 4'b1011;
    drive();
    watch2 = 1'b1;
    cycle(1'b1);
    bus.req_mask = 4'b1010;
    repeat (20) cycle(1'b1);
    watch2 = 1'b0;
    build_grants();
    for (int k = 0; k < 5; k++) begin
      check("t5_gsrc", qget(g_src, k), exp_src5[k]);
      check("t5_glen", qget(g_len, k), 2);
    end
    check("t5_no_req2", saw2, 0);

    // 6: asynchronous reset mid-burst after the pointer has moved to 3
    do_reset();
    beats_left[2] = 1;
    drive();
    repeat (3) cycle(1'b1);
    beats_left[0] = 5;
    drive();
    cycle(1'b1);
    cycle(1'b1);
    #2;
    check("t6_pre_valid", bus.nar_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", bus.req_ready, 0);
    check("t6_rst_valid", bus.nar_valid, 0);
    check("t6_rst_busy", busy, 0);
    beats_left[1] = 1;
    beats_left[3] = 1;
    drive();
    cycle(1'b1);
    cycle(1'b1);
    rst = 1'b0;
    clear_logs();
    repeat (10) cycle(1'b1);
    build_grants();
    check("t6_g0_src", qget(g_src, 0), 0);
    check("t6_g0_len", qget(g_len, 0), 4);
    check("t6_g0_data", dget(0), data_of(0, 1));
    check("t6_g1_src", qget(g_src, 1), 1);
    check("t6_g2_src", qget(g_src, 2), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
